// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control path: states, ALU codes,
// opcodes, mux selects and the per-state Moore control word.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_JALR     = 4'd10,
      S_LUI      = 4'd11,
      S_BRANCH   = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   localparam state_t RESET_STATE = S_FETCH;

   // Must stay identical to the ALU's own operation decode.
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SRA  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_XOR  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1111;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;
   localparam logic [1:0] SRC_A_ZERO   = 2'b11;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] RES_ALU_OUT = 2'b00;
   localparam logic [1:0] RES_MEM     = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   typedef enum logic [1:0] {
      ALU_OP_ADD    = 2'd0,
      ALU_OP_BRANCH = 2'd1,
      ALU_OP_FUNCT  = 2'd2
   } alu_op_t;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
   } ctrl_t;

   function automatic ctrl_t state_ctrl(input state_t st);
      ctrl_t c;
      c = '0;
      case (st)
         S_FETCH: begin
            c.pc_write   = 1'b1;
            c.ir_write   = 1'b1;
            c.result_src = RES_ALU;
            c.alu_src_a  = SRC_A_PC;
            c.alu_src_b  = SRC_B_FOUR;
         end
         S_DECODE: begin
            c.alu_src_a = SRC_A_OLD_PC;
            c.alu_src_b = SRC_B_IMM;
         end
         S_MEMADR, S_EXECI, S_JALR: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
         end
         S_MEMREAD:  c.adr_src = 1'b1;
         S_MEMWB: begin
            c.result_src = RES_MEM;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECR, S_BRANCH: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_RS2;
         end
         S_ALUWB: begin
            c.result_src = RES_ALU_OUT;
            c.reg_write  = 1'b1;
         end
         S_JAL: begin
            c.pc_write   = 1'b1;
            c.result_src = RES_ALU_OUT;
            c.alu_src_a  = SRC_A_OLD_PC;
            c.alu_src_b  = SRC_B_FOUR;
         end
         S_LUI: begin
            c.alu_src_a = SRC_A_ZERO;
            c.alu_src_b = SRC_B_IMM;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic alu_op_t state_alu_op(input state_t st);
      case (st)
         S_EXECR, S_EXECI: return ALU_OP_FUNCT;
         S_BRANCH:         return ALU_OP_BRANCH;
         default:          return ALU_OP_ADD;
      endcase
   endfunction

   function automatic logic [2:0] imm_decode(input logic [6:0] op);
      case (op)
         OP_STORE:         return IMM_S;
         OP_BRANCH:        return IMM_B;
         OP_JAL:           return IMM_J;
         OP_LUI, OP_AUIPC: return IMM_U;
         default:          return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Maps the ALU operation class plus funct fields onto the 4-bit ALU code.
module alu_decoder
   import multicycle_control_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output logic [3:0] alu_control
);

   // Combinational ALU code selection.
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALU_OP_BRANCH: begin
            case (funct3[2:1])
               2'b00:   alu_control = ALU_SUB;
               2'b10:   alu_control = ALU_SLT;
               2'b11:   alu_control = ALU_SLTU;
               default: alu_control = ALU_ADD;
            endcase
         end
         ALU_OP_FUNCT: begin
            case (funct3)
               // Immediate forms have no subtract; instr[30] is part of the imm there.
               3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_SLTU;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: one instruction at a time,
// Moore control word registered alongside the state.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] imm_src,
   output logic [3:0] alu_control,
   output logic       illegal,
   output logic [3:0] state
);

   state_t     state_r;
   state_t     state_next_s;
   ctrl_t      ctrl_r;
   ctrl_t      ctrl_next_s;
   alu_op_t    alu_op_next_s;
   logic [3:0] alu_control_r;
   logic [3:0] alu_control_next_s;
   logic       illegal_r;
   logic       is_rtype_s;
   logic       branch_taken_s;

   assign is_rtype_s    = (opcode == OP_R);
   assign ctrl_next_s   = state_ctrl(state_next_s);
   assign alu_op_next_s = state_alu_op(state_next_s);

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op_next_s),
      .funct3      (funct3),
      .funct7_5    (funct7_5),
      .is_rtype    (is_rtype_s),
      .alu_control (alu_control_next_s)
   );

   // Next-state selection.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_FETCH:  state_next_s = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
               OP_R:              state_next_s = S_EXECR;
               OP_I:              state_next_s = S_EXECI;
               OP_JAL:            state_next_s = S_JAL;
               OP_JALR:           state_next_s = S_JALR;
               OP_BRANCH:         state_next_s = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
               OP_LUI:            state_next_s = S_LUI;
               OP_AUIPC:          state_next_s = S_ALUWB;
               default:           state_next_s = S_TRAP;
            endcase
         end
         S_MEMADR:   state_next_s = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_next_s = S_MEMWB;
         S_MEMWB:    state_next_s = S_FETCH;
         S_MEMWRITE: state_next_s = S_FETCH;
         S_EXECR:    state_next_s = S_ALUWB;
         S_EXECI:    state_next_s = S_ALUWB;
         S_ALUWB:    state_next_s = S_FETCH;
         S_JALR:     state_next_s = S_JAL;
         S_JAL:      state_next_s = S_ALUWB;
         S_LUI:      state_next_s = S_ALUWB;
         S_BRANCH:   state_next_s = S_FETCH;
         S_TRAP:     state_next_s = S_TRAP;
         default:    state_next_s = S_TRAP;
      endcase
   end

   // State plus control word; reset preloads FETCH so the first edge fetches.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r       <= RESET_STATE;
         ctrl_r        <= state_ctrl(RESET_STATE);
         alu_control_r <= ALU_ADD;
         illegal_r     <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         ctrl_r        <= ctrl_next_s;
         alu_control_r <= alu_control_next_s;
         illegal_r     <= (state_next_s == S_TRAP);
      end
   end

   // beq/bge/bgeu take on zero, bne/blt/bltu on !zero.
   assign branch_taken_s = zero ^ funct3[0] ^ funct3[2];

   // Enables are gated by resetn so nothing is written while reset is held.
   assign pc_write    = resetn & (ctrl_r.pc_write | ((state_r == S_BRANCH) & branch_taken_s));
   assign adr_src     = ctrl_r.adr_src;
   assign mem_write   = resetn & ctrl_r.mem_write;
   assign ir_write    = resetn & ctrl_r.ir_write;
   assign reg_write   = resetn & ctrl_r.reg_write;
   assign result_src  = ctrl_r.result_src;
   assign alu_src_a   = ctrl_r.alu_src_a;
   assign alu_src_b   = ctrl_r.alu_src_b;
   assign imm_src     = imm_decode(opcode);
   assign alu_control = alu_control_r;
   assign illegal     = illegal_r;
   assign state       = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: expected per-cycle output
// vectors are queued as each instruction is issued and compared at negedge.
module tb_multicycle_control;

   localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
      ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5, ST_EXECR = 4'd6,
      ST_EXECI = 4'd7, ST_ALUWB = 4'd8, ST_JAL = 4'd9, ST_JALR = 4'd10,
      ST_LUI = 4'd11, ST_BRANCH = 4'd12, ST_TRAP = 4'd13;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [6:0] opcode = 7'b0110011;
   logic [2:0] funct3 = 3'b000;
   logic       funct7_5 = 1'b0;
   logic       zero = 1'b0;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] imm_src;
   logic [3:0] alu_control, state;

   logic [22:0] exp_q[$];
   string       tag_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [2:0]  cur_imm = 3'b000;
   logic [22:0] obs;

   multicycle_control dut (
      .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3),
      .funct7_5(funct7_5), .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {state, pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal};

   function automatic logic [22:0] ev(input logic [3:0] st, input logic pcw, input logic adr,
                                      input logic mw, input logic irw, input logic rw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [3:0] alu,
                                      input logic ill);
      return {st, pcw, adr, mw, irw, rw, rs, sa, sb, cur_imm, alu, ill};
   endfunction

   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         7'b0100011: return 3'b001;
         7'b1100011: return 3'b010;
         7'b1101111: return 3'b011;
         7'b0110111: return 3'b100;
         7'b0010111: return 3'b100;
         default:    return 3'b000;
      endcase
   endfunction

   function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic rtype);
      case (f3)
         3'b000:  return (rtype && f7) ? 4'b0110 : 4'b0010;
         3'b001:  return 4'b1000;
         3'b010:  return 4'b0111;
         3'b011:  return 4'b1111;
         3'b100:  return 4'b1010;
         3'b101:  return f7 ? 4'b0011 : 4'b1001;
         3'b110:  return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] br_alu(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001: return 4'b0110;
         3'b100, 3'b101: return 4'b0111;
         3'b110, 3'b111: return 4'b1111;
         default:        return 4'b0010;
      endcase
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic z);
      case (f3)
         3'b000:  return z;
         3'b001:  return !z;
         3'b100:  return !z;
         3'b101:  return z;
         3'b110:  return !z;
         3'b111:  return z;
         default: return 1'b0;
      endcase
   endfunction

   task automatic push(input string t, input logic [22:0] v);
      exp_q.push_back(v);
      tag_q.push_back(t);
   endtask

   task automatic check_cycle();
      logic [22:0] e;
      string       t;
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = exp_q.size();
      for (int i = 0; i < n; i++) check_cycle();
   endtask

   task automatic do_reset(input string name, input int n);
      resetn = 1'b0;
      for (int i = 0; i < n; i++)
         push({name, "_reset"}, ev(ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   2'b10, 2'b00, 2'b10, 4'b0010, 1'b0));
      drain();
      resetn = 1'b1;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
      opcode   = op;
      funct3   = f3;
      funct7_5 = f7;
      zero     = z;
      cur_imm  = imm_of(op);
   endtask

   task automatic push_trap(input string name, input int n);
      for (int i = 0; i < n; i++)
         push({name, "_trap"}, ev(ST_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  2'b00, 2'b00, 2'b00, 4'b0010, 1'b1));
   endtask

   task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z);
      set_instr(op, f3, f7, z);
      push({name, "_fetch"},  ev(ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 4'b0010, 1'b0));
      push({name, "_decode"}, ev(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 4'b0010, 1'b0));
      case (op)
         7'b0000011: begin
            push({name, "_memadr"},  ev(ST_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0010, 1'b0));
            push({name, "_memread"}, ev(ST_MEMREAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0));
            push({name, "_memwb"},   ev(ST_MEMWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 4'b0010, 1'b0));
         end
         7'b0100011: begin
            push({name, "_memadr"},   ev(ST_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0010, 1'b0));
            push({name, "_memwrite"}, ev(ST_MEMWRITE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0));
         end
         7'b0110011: begin
            push({name, "_execr"}, ev(ST_EXECR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu_ref(f3, f7, 1'b1), 1'b0));
            push({name, "_aluwb"}, ev(ST_ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0));
         end
         7'b0010011: begin
            push({name, "_execi"}, ev(ST_EXECI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu_ref(f3, f7, 1'b0), 1'b0));
            push({name, "_aluwb"}, ev(ST_ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0));
         end
         7'b1101111, 7'b1100111: begin
            if (op == 7'b1100111)
               push({name, "_jalr"}, ev(ST_JALR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0010, 1'b0));
            push({name, "_jal"},   ev(ST_JAL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 4'b0010, 1'b0));
            push({name, "_aluwb"}, ev(ST_ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0));
         end
         7'b0110111: begin
            push({name, "_lui"},   ev(ST_LUI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 4'b0010, 1'b0));
            push({name, "_aluwb"}, ev(ST_ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0));
         end
         7'b0010111:
            push({name, "_aluwb"}, ev(ST_ALUWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0));
         7'b1100011: begin
            if (f3 == 3'b010 || f3 == 3'b011)
               push_trap(name, 12);
            else
               push({name, "_branch"}, ev(ST_BRANCH, br_taken(f3, z), 1'b0, 1'b0, 1'b0, 1'b0,
                                          2'b00, 2'b10, 2'b00, br_alu(f3), 1'b0));
         end
         default: push_trap(name, 12);
      endcase
      drain();
   endtask

   initial begin
      #1;
      do_reset("por", 3);
      run_instr("sub",  7'b0110011, 3'b000, 1'b1, 1'b0);
      run_instr("add",  7'b0110011, 3'b000, 1'b0, 1'b0);
      run_instr("srai", 7'b0010011, 3'b101, 1'b1, 1'b0);
      run_instr("srli", 7'b0010011, 3'b101, 1'b0, 1'b0);
      run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0);
      for (int f = 1; f < 8; f++)
         run_instr($sformatf("rtype_f%0d", f), 7'b0110011, 3'(f), 1'b0, 1'b0);
      run_instr("lw",  7'b0000011, 3'b010, 1'b0, 1'b0);
      run_instr("sw",  7'b0100011, 3'b010, 1'b0, 1'b0);
      run_instr("bge_z1",  7'b1100011, 3'b101, 1'b0, 1'b1);
      run_instr("bge_z0",  7'b1100011, 3'b101, 1'b0, 1'b0);
      run_instr("bne_z0",  7'b1100011, 3'b001, 1'b0, 1'b0);
      run_instr("beq_z1",  7'b1100011, 3'b000, 1'b0, 1'b1);
      run_instr("bltu_z0", 7'b1100011, 3'b110, 1'b0, 1'b0);
      run_instr("bgeu_z0", 7'b1100011, 3'b111, 1'b0, 1'b0);
      run_instr("jal",   7'b1101111, 3'b000, 1'b0, 1'b0);
      run_instr("jalr",  7'b1100111, 3'b000, 1'b0, 1'b0);
      run_instr("lui",   7'b0110111, 3'b000, 1'b0, 1'b0);
      run_instr("auipc", 7'b0010111, 3'b000, 1'b0, 1'b0);

      // Abort a store while it is in MEMWRITE: mem_write must drop at once.
      set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      push("abort_fetch",  ev(ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 4'b0010, 1'b0));
      push("abort_decode", ev(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 4'b0010, 1'b0));
      push("abort_memadr", ev(ST_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0010, 1'b0));
      drain();
      do_reset("abort", 2);
      run_instr("post_abort_add", 7'b0110011, 3'b000, 1'b0, 1'b0);

      run_instr("br_f010", 7'b1100011, 3'b010, 1'b0, 1'b1);
      do_reset("br_f010", 2);
      run_instr("illegal_op", 7'b1111111, 3'b000, 1'b0, 1'b0);
      do_reset("illegal_op", 2);
      run_instr("post_trap_addi", 7'b0010011, 3'b000, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I core; sits directly upstream of the ALU.
- Sequences fetch, decode, execute, memory and writeback one instruction at a time.
- Drives ALU operand-select muxes and the 4-bit alu_control code.
- Consumes the ALU zero flag to resolve branches.

Parameters:
- RESET_STATE, FETCH, state entered on reset (fixed; listed for bench visibility only).

Ports:
- clk  input  1  core clock
- resetn  input  1  asynchronous active-low reset
- opcode  input  7  instr[6:0] from instruction register
- funct3  input  3  instr[14:12]
- funct7_5  input  1  instr[30]
- zero  input  1  ALU zero flag
- pc_write  output  1  PC register load enable
- adr_src  output  1  memory address: 0=PC, 1=alu_out register
- mem_write  output  1  data memory write strobe
- ir_write  output  1  instruction register and old_pc load enable
- reg_write  output  1  register file write enable
- result_src  output  2  00=alu_out reg, 01=mem data reg, 10=live ALU result
- alu_src_a  output  2  00=PC, 01=old_pc, 10=rs1 reg A, 11=zero
- alu_src_b  output  2  00=rs2 reg B, 01=imm, 10=const 4
- imm_src  output  3  I=000, S=001, B=010, J=011, U=100
- alu_control  output  4  ALU operation code
- illegal  output  1  sticky illegal-instruction flag
- state  output  4  current state (debug)

Behaviour:
- Reset is asynchronous and active-low:
  - resetn low -> state=FETCH, illegal=0.
  - All enables (pc_write, mem_write, ir_write, reg_write) are forced 0 while resetn is low.
  - The first fetch happens on the first rising clk edge after release.
- Outputs are Moore (state-decoded), with two exceptions: pc_write in BRANCH depends on zero; imm_src is decoded from opcode in every state.
- Default output value in every state: 0, with alu_control=ADD(0010).
- ALU codes: AND 0000, OR 0001, ADD 0010, SRA 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, XOR 1010, SLTU 1111.
- Execute decode, by funct3:
  - 000: ADD, or SUB when R-type and funct7_5=1
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when funct7_5=1 (R-type and I-type)
  - 110: OR
  - 111: AND
- States and transitions:
  - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, ADD, result_src=10, pc_write=1 -> DECODE.
  - DECODE: src_a=01, src_b=01, ADD (alu_out <= old_pc+imm). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 1100011 -> BRANCH, but only if funct3 is not 010 or 011; otherwise TRAP
    - 0110111 -> LUI
    - 0010111 -> ALUWB (auipc)
    - anything else -> TRAP
  - MEMADR: src_a=10, src_b=01, ADD -> MEMREAD if load, else MEMWRITE.
  - MEMREAD: adr_src=1 -> MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: adr_src=1, mem_write=1 -> FETCH.
  - EXECR: src_a=10, src_b=00, funct decode -> ALUWB.
  - EXECI: src_a=10, src_b=01, funct decode -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - JALR: src_a=10, src_b=01, ADD (alu_out <= rs1+imm) -> JAL. Target bit 0 is cleared in the datapath, not here.
  - JAL: result_src=00, pc_write=1 (PC <= alu_out), src_a=01, src_b=10, ADD (alu_out <= old_pc+4) -> ALUWB.
  - LUI: src_a=11, src_b=01, ADD -> ALUWB.
  - BRANCH: src_a=10, src_b=00, result_src=00 -> FETCH.
    - beq: SUB, taken on zero
    - bne: SUB, taken on !zero
    - blt: SLT, taken on !zero
    - bge: SLT, taken on zero
    - bltu: SLTU, taken on !zero
    - bgeu: SLTU, taken on zero
    - pc_write = taken.
  - TRAP: illegal=1, all enables 0, stays in TRAP until reset.
- Latency in cycles, FETCH inclusive: load 5, store 4, R/I 4, branch 3, jal 4, jalr 5, lui 4, auipc 3.
- Reset mid-instruction aborts it immediately. No partial register or memory write occurs after resetn falls.

Decomposition:
- Shared package holds:
  - state enum (4-bit)
  - ALU op codes
  - opcode constants
  - src_a, src_b, result_src and imm_src encodings
- The ALU op codes in the package must match the ALU's decode exactly.
- One combinational sub-module, alu_decoder: inputs are an alu_op class (add / branch / funct), funct3, funct7_5 and an is_rtype flag; output is alu_control.

Test Plan:
- Reset held 3 cycles with opcode=0110011 -> all enables 0, state=FETCH. First edge after release gives ir_write=1 and pc_write=1.
- R-type sub (opcode 0110011, funct3 000, funct7_5=1) -> state FETCH, DECODE, EXECR (alu_control=0110), ALUWB (reg_write=1), then FETCH.
- I-type srai (0010011, 101, funct7_5=1) -> alu_control=0011 in EXECI. Same instruction with funct7_5=0 -> 1001.
- lw: 5 cycles, MEMREAD has adr_src=1, MEMWB has result_src=01 and reg_write=1. sw: 4 cycles, mem_write=1 only in MEMWRITE.
- Branches:
  - bge (funct3 101): zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; alu_control=0111 in both cases.
  - bne: zero=0 -> pc_write=1.
  - funct3 010 -> TRAP.
- Illegal opcode 1111111 -> illegal=1 and stays; enables stay 0 for 10+ cycles. Asserting resetn low clears illegal.
